// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared core types and constants for the decode/execute pipeline
//
// Contents:
//   WORD_WIDTH_DEF / CTRL_WIDTH_DEF  default datapath and control-bundle widths
//   pipe_state_e                     occupancy state of the ID/EX register stage
//   CTRL_*                           bit positions inside the packed decode-control bundle
//   CTRL_SIDE_EFFECT_MASK            control bits that must never leak out of an invalid entry
package core_pkg;

   localparam int WORD_WIDTH_DEF = 32;
   localparam int CTRL_WIDTH_DEF = 24;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } pipe_state_e;

   // Decode-control bundle layout
   localparam int CTRL_REG_WE_BIT  = 0;
   localparam int CTRL_MEM_WE_BIT  = 1;
   localparam int CTRL_MEM_RE_BIT  = 2;
   localparam int CTRL_BRANCH_BIT  = 3;
   localparam int CTRL_JUMP_BIT    = 4;
   localparam int CTRL_ALU_OP_LSB  = 5;
   localparam int CTRL_ALU_OP_W    = 5;
   localparam int CTRL_IMM_SEL_LSB = 10;
   localparam int CTRL_IMM_SEL_W   = 3;
   localparam int CTRL_RD_LSB      = 13;
   localparam int CTRL_RD_W        = 5;

   // Register write-enable and store-enable are the bits with architectural side effects
   localparam logic [CTRL_WIDTH_DEF-1:0] CTRL_SIDE_EFFECT_MASK =
      CTRL_WIDTH_DEF'((1 << CTRL_REG_WE_BIT) | (1 << CTRL_MEM_WE_BIT));

endpackage

// File: rtl/fwd_mux.sv
// rtl/fwd_mux.sv - priority forwarding select for one register operand
//
// Ports:
//   op_rdata  in  WORD_WIDTH            register-file read value for this operand
//   fwd_data  in  NUM_FWD x WORD_WIDTH  forwarding sources, index 0 is the youngest producer
//   fwd_sel   in  NUM_FWD               forward request bits for this operand
//   op_data   out WORD_WIDTH            selected operand value
module fwd_mux #(
   parameter int NUM_FWD    = 2,
   parameter int WORD_WIDTH = 32
) (
   input  logic [WORD_WIDTH-1:0]         op_rdata,
   input  logic [NUM_FWD*WORD_WIDTH-1:0] fwd_data,
   input  logic [NUM_FWD-1:0]            fwd_sel,
   output logic [WORD_WIDTH-1:0]         op_data
);

   // Walking from oldest to youngest lets the lowest requested index win.
   always_comb begin
      op_data = op_rdata;
      for (int j = NUM_FWD - 1; j >= 0; j--) begin
         if (fwd_sel[j]) begin
            op_data = fwd_data[j*WORD_WIDTH +: WORD_WIDTH];
         end
      end
   end

endmodule

// File: rtl/id_ex_pipe.sv
// rtl/id_ex_pipe.sv - ID/EX pipeline register with skid entry and operand forwarding capture
//
// Ports:
//   clk, rst_n    clock and asynchronous active-low reset
//   flush_i       drop every held entry and the current input
//   in_valid_i    ID presents an instruction; in_ready_o: stage can accept (decoded from state)
//   pc_i, instr_i instruction PC and word; ctrl_i decode-control bundle
//   rdata_i       NUM_OPS register-file read values, operand k at [k*WORD_WIDTH +: WORD_WIDTH]
//   fwd_data_i    NUM_FWD forwarding values, source j at [j*WORD_WIDTH +: WORD_WIDTH]
//   fwd_sel_i     forward request bits, operand k at [k*NUM_FWD +: NUM_FWD]
//   out_valid_o   head entry valid; out_ready_i: EX consumes the head entry
//   pc_o, instr_o, ctrl_o, rdata_o  head entry contents
//   stall_cnt_o   saturating count of cycles the head entry was offered but not consumed
module id_ex_pipe
   import core_pkg::*;
#(
   parameter int                    WORD_WIDTH     = WORD_WIDTH_DEF,
   parameter int                    CTRL_WIDTH     = CTRL_WIDTH_DEF,
   parameter int                    NUM_OPS        = 2,
   parameter int                    NUM_FWD        = 2,
   parameter logic [CTRL_WIDTH-1:0] CTRL_KILL_MASK = '0
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          flush_i,
   input  logic                          in_valid_i,
   output logic                          in_ready_o,
   input  logic [WORD_WIDTH-1:0]         pc_i,
   input  logic [WORD_WIDTH-1:0]         instr_i,
   input  logic [CTRL_WIDTH-1:0]         ctrl_i,
   input  logic [NUM_OPS*WORD_WIDTH-1:0] rdata_i,
   input  logic [NUM_FWD*WORD_WIDTH-1:0] fwd_data_i,
   input  logic [NUM_OPS*NUM_FWD-1:0]    fwd_sel_i,
   output logic                          out_valid_o,
   input  logic                          out_ready_i,
   output logic [WORD_WIDTH-1:0]         pc_o,
   output logic [WORD_WIDTH-1:0]         instr_o,
   output logic [CTRL_WIDTH-1:0]         ctrl_o,
   output logic [NUM_OPS*WORD_WIDTH-1:0] rdata_o,
   output logic [15:0]                   stall_cnt_o
);

   pipe_state_e state_q;
   pipe_state_e state_d;

   logic accept;
   logic emit;
   logic skid_valid;
   logic load_main_in;
   logic load_main_skid;
   logic load_skid;

   logic [NUM_OPS*WORD_WIDTH-1:0] cap_ops;

   logic [WORD_WIDTH-1:0]         main_pc;
   logic [WORD_WIDTH-1:0]         main_instr;
   logic [CTRL_WIDTH-1:0]         main_ctrl;
   logic [NUM_OPS*WORD_WIDTH-1:0] main_ops;

   logic [WORD_WIDTH-1:0]         skid_pc;
   logic [WORD_WIDTH-1:0]         skid_instr;
   logic [CTRL_WIDTH-1:0]         skid_ctrl;
   logic [NUM_OPS*WORD_WIDTH-1:0] skid_ops;

   // Operands are resolved once, on the way in; held entries never see later forwarding.
   for (genvar k = 0; k < NUM_OPS; k++) begin : g_op
      fwd_mux #(
         .NUM_FWD    (NUM_FWD),
         .WORD_WIDTH (WORD_WIDTH)
      ) u_fwd_mux (
         .op_rdata (rdata_i[k*WORD_WIDTH +: WORD_WIDTH]),
         .fwd_data (fwd_data_i),
         .fwd_sel  (fwd_sel_i[k*NUM_FWD +: NUM_FWD]),
         .op_data  (cap_ops[k*WORD_WIDTH +: WORD_WIDTH])
      );
   end

   // in_ready_o and out_valid_o come straight from the state flops, so out_ready_i
   // only reaches in_ready_o through a clock edge.
   assign accept = in_valid_i & in_ready_o & ~flush_i;
   assign emit   = out_valid_o & out_ready_i;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_EMPTY;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d        = state_q;
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
      if (flush_i) begin
         state_d = ST_EMPTY;
      end else begin
         case (state_q)
            ST_EMPTY: begin
               if (accept) begin
                  state_d      = ST_ONE;
                  load_main_in = 1'b1;
               end
            end
            ST_ONE: begin
               if (accept && emit) begin
                  load_main_in = 1'b1;
               end else if (accept) begin
                  state_d   = ST_FULL;
                  load_skid = 1'b1;
               end else if (emit) begin
                  state_d = ST_EMPTY;
               end
            end
            ST_FULL: begin
               if (emit) begin
                  state_d        = ST_ONE;
                  load_main_skid = 1'b1;
               end
            end
            default: state_d = ST_EMPTY;
         endcase
      end
   end

   always_comb begin
      out_valid_o = (state_q != ST_EMPTY);
      skid_valid  = (state_q == ST_FULL);
      in_ready_o  = ~skid_valid;
      // Side-effect bits are killed whenever the head is not a live instruction.
      ctrl_o      = out_valid_o ? main_ctrl : (main_ctrl & ~CTRL_KILL_MASK);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         main_pc    <= '0;
         main_instr <= '0;
         main_ctrl  <= '0;
         main_ops   <= '0;
         skid_pc    <= '0;
         skid_instr <= '0;
         skid_ctrl  <= '0;
         skid_ops   <= '0;
      end else begin
         if (load_main_in) begin
            main_pc    <= pc_i;
            main_instr <= instr_i;
            main_ctrl  <= ctrl_i;
            main_ops   <= cap_ops;
         end else if (load_main_skid) begin
            main_pc    <= skid_pc;
            main_instr <= skid_instr;
            main_ctrl  <= skid_ctrl;
            main_ops   <= skid_ops;
         end
         if (load_skid) begin
            skid_pc    <= pc_i;
            skid_instr <= instr_i;
            skid_ctrl  <= ctrl_i;
            skid_ops   <= cap_ops;
         end
      end
   end

   assign pc_o    = main_pc;
   assign instr_o = main_instr;
   assign rdata_o = main_ops;

   // Counts offered-but-not-taken cycles regardless of flush.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt_o <= '0;
      end else if (out_valid_o && !out_ready_i && (stall_cnt_o != 16'hFFFF)) begin
         stall_cnt_o <= stall_cnt_o + 16'd1;
      end
   end

endmodule

// File: tb/tb_id_ex_pipe.sv
// tb/tb_id_ex_pipe.sv - self-checking bench for id_ex_pipe
module tb_id_ex_pipe;
   import core_pkg::*;

   localparam int W  = 32;
   localparam int C  = 24;
   localparam int NO = 2;
   localparam int NF = 2;
   localparam logic [C-1:0] KM = CTRL_SIDE_EFFECT_MASK;

   logic            clk;
   logic            rst_n;
   logic            flush;
   logic            in_valid;
   logic            in_ready;
   logic [W-1:0]    pc;
   logic [W-1:0]    instr;
   logic [C-1:0]    ctrl;
   logic [NO*W-1:0] rdata;
   logic [NF*W-1:0] fwd_data;
   logic [NO*NF-1:0] fwd_sel;
   logic            out_valid;
   logic            out_ready;
   logic [W-1:0]    pc_o;
   logic [W-1:0]    instr_o;
   logic [C-1:0]    ctrl_o;
   logic [NO*W-1:0] rdata_o;
   logic [15:0]     stall_cnt;

   int checks = 0;
   int errors = 0;

   id_ex_pipe #(
      .WORD_WIDTH     (W),
      .CTRL_WIDTH     (C),
      .NUM_OPS        (NO),
      .NUM_FWD        (NF),
      .CTRL_KILL_MASK (KM)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .flush_i     (flush),
      .in_valid_i  (in_valid),
      .in_ready_o  (in_ready),
      .pc_i        (pc),
      .instr_i     (instr),
      .ctrl_i      (ctrl),
      .rdata_i     (rdata),
      .fwd_data_i  (fwd_data),
      .fwd_sel_i   (fwd_sel),
      .out_valid_o (out_valid),
      .out_ready_i (out_ready),
      .pc_o        (pc_o),
      .instr_o     (instr_o),
      .ctrl_o      (ctrl_o),
      .rdata_o     (rdata_o),
      .stall_cnt_o (stall_cnt)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // ---------------- behavioural model: a two-deep FIFO of resolved instructions
   typedef struct {
      logic [W-1:0] pc;
      logic [W-1:0] instr;
      logic [C-1:0] ctrl;
      logic [W-1:0] op0;
      logic [W-1:0] op1;
   } entry_t;

   entry_t      q[$];
   logic [15:0] m_stall = 16'd0;
   bit          m_acc;
   bit          m_emt;
   entry_t      m_e;

   function automatic logic [W-1:0] pick(input logic [W-1:0] rd, input logic [1:0] sel,
                                         input logic [W-1:0] f0, input logic [W-1:0] f1);
      if (sel[0]) return f0;
      if (sel[1]) return f1;
      return rd;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q.delete();
         m_stall = 16'd0;
      end else begin
         m_acc = in_valid && (q.size() < 2) && !flush;
         m_emt = (q.size() > 0) && out_ready;
         if ((q.size() > 0) && !out_ready && (m_stall != 16'hFFFF)) m_stall = m_stall + 16'd1;
         if (flush) begin
            q.delete();
         end else begin
            if (m_emt) void'(q.pop_front());
            if (m_acc) begin
               m_e.pc    = pc;
               m_e.instr = instr;
               m_e.ctrl  = ctrl;
               m_e.op0   = pick(rdata[31:0],  fwd_sel[1:0], fwd_data[31:0], fwd_data[63:32]);
               m_e.op1   = pick(rdata[63:32], fwd_sel[3:2], fwd_data[31:0], fwd_data[63:32]);
               q.push_back(m_e);
            end
         end
      end
   end

   // ---------------- every-cycle comparison against the model
   always @(negedge clk) begin
      check("out_valid", 64'(out_valid), 64'(q.size() > 0));
      check("in_ready",  64'(in_ready),  64'(q.size() < 2));
      check("stall_cnt", 64'(stall_cnt), 64'(m_stall));
      if (q.size() > 0) begin
         check("pc_o",    64'(pc_o),          64'(q[0].pc));
         check("instr_o", 64'(instr_o),       64'(q[0].instr));
         check("ctrl_o",  64'(ctrl_o),        64'(q[0].ctrl));
         check("op0",     64'(rdata_o[31:0]), 64'(q[0].op0));
         check("op1",     64'(rdata_o[63:32]),64'(q[0].op1));
      end else begin
         check("ctrl_kill", 64'(ctrl_o & KM), 64'd0);
      end
   end

   // ---------------- stimulus
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic present(input logic v, input logic [W-1:0] p);
      in_valid = v;
      pc       = p;
      instr    = p ^ 32'hA5A5_0000;
      ctrl     = 24'hC0_0003 ^ {p[15:0], 8'h00};
      rdata    = {p + 32'h200, p + 32'h100};
   endtask

   initial begin
      rst_n     = 1'b0;
      flush     = 1'b0;
      out_ready = 1'b0;
      fwd_sel   = '0;
      fwd_data  = '0;
      present(1'b0, 32'h0);
      #2;
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_in_ready",  64'(in_ready),  64'd1);
      check("rst_stall",     64'(stall_cnt), 64'd0);
      check("rst_pc",        64'(pc_o),      64'd0);
      tick();
      tick();
      rst_n = 1'b1;

      // Streaming at full rate
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         present(1'b1, 32'(i * 4));
         tick();
         check("stream_valid", 64'(out_valid), 64'd1);
         check("stream_pc",    64'(pc_o),      64'(i * 4));
         check("stream_ready", 64'(in_ready),  64'd1);
      end
      present(1'b0, 32'h0);
      tick();
      check("stream_drain", 64'(out_valid), 64'd0);

      // Fill to FULL under backpressure, input blocked, then release
      out_ready = 1'b0;
      present(1'b1, 32'h20);
      tick();
      present(1'b1, 32'h10);
      tick();
      check("full_ready", 64'(in_ready), 64'd0);
      check("full_head",  64'(pc_o),     64'h20);
      present(1'b1, 32'h99);
      repeat (3) tick();
      check("hold_stall", 64'(stall_cnt), 64'd4);
      check("hold_head",  64'(pc_o),      64'h20);
      present(1'b0, 32'h0);
      out_ready = 1'b1;
      tick();
      check("rel_pc",    64'(pc_o),     64'h10);
      check("rel_ready", 64'(in_ready), 64'd1);
      tick();
      check("rel_empty", 64'(out_valid), 64'd0);

      // Forwarding priority
      fwd_data = {32'h33, 32'h22};
      present(1'b1, 32'h30);
      rdata   = {32'h44, 32'h11};
      fwd_sel = 4'b00_11;
      tick();
      check("fwd_lowest", 64'(rdata_o[31:0]),  64'h22);
      check("fwd_none",   64'(rdata_o[63:32]), 64'h44);
      present(1'b1, 32'h34);
      fwd_sel = 4'b01_10;
      tick();
      check("fwd_hi",     64'(rdata_o[31:0]),  64'h33);
      check("fwd_op1",    64'(rdata_o[63:32]), 64'h22);
      present(1'b0, 32'h0);
      out_ready = 1'b0;
      fwd_data  = {32'hDEAD, 32'hBEEF};
      tick();
      check("no_refwd",   64'(rdata_o[31:0]),  64'h33);
      out_ready = 1'b1;
      fwd_sel   = '0;
      tick();

      // Flush while FULL with a live input
      out_ready = 1'b0;
      present(1'b1, 32'h40);
      tick();
      present(1'b1, 32'h44);
      tick();
      present(1'b1, 32'h48);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      present(1'b0, 32'h0);
      check("flush_valid", 64'(out_valid),   64'd0);
      check("flush_ready", 64'(in_ready),    64'd1);
      check("flush_ctrl",  64'(ctrl_o & KM), 64'd0);
      check("flush_stall", 64'(stall_cnt),   64'd7);
      out_ready = 1'b1;
      tick();

      // Asynchronous reset while FULL
      out_ready = 1'b0;
      present(1'b1, 32'h50);
      tick();
      present(1'b1, 32'h54);
      tick();
      present(1'b0, 32'h0);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_valid", 64'(out_valid), 64'd0);
      check("arst_ready", 64'(in_ready),  64'd1);
      check("arst_stall", 64'(stall_cnt), 64'd0);
      check("arst_pc",    64'(pc_o),      64'd0);
      check("arst_ctrl",  64'(ctrl_o),    64'd0);
      tick();
      rst_n     = 1'b1;
      out_ready = 1'b1;
      present(1'b1, 32'h60);
      tick();
      check("post_rst_pc", 64'(pc_o), 64'h60);

      // Stall counter saturation
      present(1'b0, 32'h0);
      out_ready = 1'b0;
      repeat (70000) tick();
      check("stall_sat", 64'(stall_cnt), 64'hFFFF);
      out_ready = 1'b1;
      tick();

      // Mixed traffic against the model
      for (int i = 0; i < 400; i++) begin
         present(1'($urandom_range(0, 1)), $urandom);
         out_ready = ($urandom_range(0, 3) != 0);
         flush     = ($urandom_range(0, 15) == 0);
         fwd_sel   = 4'($urandom);
         fwd_data  = {$urandom, $urandom};
         tick();
      end
      flush = 1'b0;
      present(1'b0, 32'h0);
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
